md_unit: RTL

- Execute-stage multiply/divide unit fed directly by the ID/EX pipeline register: consumes operand values, the decoded multiply/divide op and an issue strobe.
- Owns the architectural HI/LO registers and runs mult/multu/div/divu as fixed-latency multi-cycle operations.
- Drives a busy/stall request to the hazard unit.
- Returns HI/LO to the EX result mux for mfhi/mflo.

---
 rtl/md_unit_pkg.sv | 26 ++
 rtl/md_unit_if.sv | 27 ++
 rtl/md_unit_arith.sv | 57 +++++
 rtl/md_unit.sv | 79 +++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared decode constants for the multiply/divide unit.
// Provides the md_op encoding used between decode, the ID/EX register and
// the execute-stage md_unit, plus the default busy latencies.
package md_unit_pkg;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_long_op(md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// Bundle between the EX stage / hazard unit and md_unit.
// master: pipeline side (drives issue, md_op, rs_val, rt_val; reads results)
// slave : md_unit side (drives busy, md_stall, hi, lo, md_rdata)
interface md_unit_if;
    import md_unit_pkg::*;

    logic        issue;
    md_op_e      md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rdata;

    modport master (
        output issue, md_op, rs_val, rt_val,
        input  busy, md_stall, hi, lo, md_rdata
    );

    modport slave (
        input  issue, md_op, rs_val, rt_val,
        output busy, md_stall, hi, lo, md_rdata
    );

endinterface

// File: rtl/md_unit_arith.sv
// md_arith: purely combinational multiply/divide datapath.
// Ports:
//   op          - decoded md_op
//   rs, rt      - operands (multiplicand/dividend, multiplier/divisor)
//   result      - {hi, lo} result for MULT/MULTU/DIV/DIVU, 0 otherwise
//   div_by_zero - high for DIV/DIVU with rt == 0
module md_arith
    import md_unit_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Signed product: the low 64 bits of a product of sign-extended operands
    // are the exact signed 32x32 result.
    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Division on magnitudes, then sign-correct. A zero divisor is replaced by
    // 1 so the datapath never sees X; the result is discarded anyway.
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negates to itself.
    always_comb begin
        div_signed  = (op == MD_DIV);
        div_by_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (rt == 32'd0);
        mag_a = (div_signed && rs[31]) ? (32'd0 - rs) : rs;
        mag_b = (div_signed && rt[31]) ? (32'd0 - rt) : rt;
        if (mag_b == 32'd0) begin
            mag_b = 32'd1;
        end
        q_mag = mag_a / mag_b;
        r_mag = mag_a % mag_b;
        quot  = (div_signed && (rs[31] ^ rt[31])) ? (32'd0 - q_mag) : q_mag;
        rem   = (div_signed && rs[31]) ? (32'd0 - r_mag) : r_mag;

        result = 64'd0;
        case (op)
            MD_MULT:          result = prod_s;
            MD_MULTU:         result = prod_u;
            MD_DIV, MD_DIVU:  result = {rem, quot};
            default:          result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk, reset - clock and asynchronous active-high reset
//   bus        - md_unit_if.slave: issue/md_op/rs_val/rt_val in;
//                busy/md_stall/hi/lo/md_rdata out
// A long op computes its result at issue, parks it in a pending register,
// and commits it to HI/LO on the edge where the busy counter reaches zero.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)(
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  bus
);

    logic [3:0]  counter;
    logic [63:0] pending;
    logic        pending_wr;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [63:0] arith_result;
    logic        arith_dz;
    logic        busy_w;

    md_arith u_arith (
        .op          (bus.md_op),
        .rs          (bus.rs_val),
        .rt          (bus.rt_val),
        .result      (arith_result),
        .div_by_zero (arith_dz)
    );

    assign busy_w = (counter != 4'd0);

    // Any issue while busy is ignored: the RUN branch takes priority, so the
    // counter keeps running and HI/LO are untouched until commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter    <= 4'd0;
            pending    <= 64'd0;
            pending_wr <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else if (busy_w) begin
            counter <= counter - 4'd1;
            if ((counter == 4'd1) && pending_wr) begin
                hi_q <= pending[63:32];
                lo_q <= pending[31:0];
            end
        end else if (bus.issue) begin
            if (is_long_op(bus.md_op)) begin
                pending    <= arith_result;
                pending_wr <= !arith_dz;
                if ((bus.md_op == MD_DIV) || (bus.md_op == MD_DIVU)) begin
                    counter <= 4'(DIV_CYCLES);
                end else begin
                    counter <= 4'(MULT_CYCLES);
                end
            end else if (bus.md_op == MD_MTHI) begin
                hi_q <= bus.rs_val;
            end else if (bus.md_op == MD_MTLO) begin
                lo_q <= bus.rs_val;
            end
        end
    end

    // The issue cycle of a long op already stalls ID so the next md-type
    // instruction cannot slip in behind it.
    assign bus.busy     = busy_w;
    assign bus.md_stall = busy_w || (bus.issue && is_long_op(bus.md_op));
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.md_rdata = (bus.md_op == MD_MFHI) ? hi_q :
                          (bus.md_op == MD_MFLO) ? lo_q : 32'd0;

endmodule
